// File: rtl/handshake_reader.sv
// Pin-side reader: synchronises a 4-phase request, acknowledges it, and queues
// accepted bytes (or fires a hash-reset pulse) towards the data router.

package handshake_reader_pkg;
  typedef enum logic [1:0] {
    I_IDLE,
    I_KEY,
    I_DATA,
    I_HASH
  } interface_state_t;
endpackage

module handshake_reader
  import handshake_reader_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                            clk,
  input  logic                            nrst,
  input  logic [DATA_W-1:0]               input_byte,
  input  logic                            is_key,
  input  logic                            reset_hash,
  input  logic                            input_request,
  output logic                            input_ack,
  input  interface_state_t                fsm_state,
  output logic [DATA_W-1:0]               out_byte,
  output logic                            out_is_key,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            reset_hash_pulse,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH+1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_REARM,
    S_IDLE,
    S_ACK
  } state_t;

  state_t              r_state;
  logic                r_ack;
  logic                r_pulse;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [DATA_W:0]     r_mem [FIFO_DEPTH];
  logic [PW-1:0]       r_wr;
  logic [PW-1:0]       r_rd;
  logic [CW-1:0]       r_count;

  logic w_req_s;
  logic w_accept;
  logic w_push;
  logic w_pop;
  logic w_nonempty;

  assign w_req_s    = r_sync[SYNC_STAGES-1];
  assign w_nonempty = (r_count != '0);
  // Accept uses the count before any same-cycle pop, so a pop never frees a slot early.
  assign w_accept   = (r_state == S_IDLE) && w_req_s && (fsm_state == I_IDLE) &&
                      (reset_hash || (r_count != DEPTH_C));
  assign w_push     = w_accept && !reset_hash;
  assign w_pop      = w_nonempty && out_ready;

  // Reset to all-ones so a request held through reset looks already high.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], input_request};
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_state <= S_REARM;
      r_ack   <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_pulse <= 1'b0;
      case (r_state)
        S_REARM: begin
          if (!w_req_s) r_state <= S_IDLE;
        end
        S_IDLE: begin
          if (w_accept) begin
            r_ack   <= 1'b1;
            r_pulse <= reset_hash;
            r_state <= S_ACK;
          end
        end
        S_ACK: begin
          if (!w_req_s) begin
            r_ack   <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_REARM;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= {is_key, input_byte};
        r_wr        <= r_wr + 1'b1;
      end
      if (w_pop) r_rd <= r_rd + 1'b1;
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  assign {out_is_key, out_byte} = w_nonempty ? r_mem[r_rd] : '0;
  assign out_valid              = w_nonempty;
  assign input_ack              = r_ack;
  assign reset_hash_pulse       = r_pulse;
  assign fifo_count             = r_count;

endmodule

// File: doc/handshake_reader.md
Name: handshake_reader

Overview:
Parametrised successor to the pin-side input reader. It terminates a full 4-phase req/ack handshake from the chip pins and synchronises the asynchronous request. Accepted data bytes go into a small FIFO that drives the data router through valid/ready. A hash-reset command produces a single-cycle pulse to the hash generator. Backpressure reaches the external host by withholding ack.

Parameters:
DATA_W, 8, width of input_byte and out_byte
SYNC_STAGES, 2, flops in the input_request synchroniser (legal range 2..4)
FIFO_DEPTH, 4, byte FIFO entries (power of 2, at least 2)

Ports:
clk  input  1  system clock; all logic on rising edge
nrst  input  1  synchronous, active-low reset
input_byte  input  DATA_W  pin data; bundled with input_request, stable while request is high
is_key  input  1  pin flag; marks byte as key material
reset_hash  input  1  pin flag; request is a hash-reset command, not data
input_request  input  1  asynchronous 4-phase request from the pins
input_ack  output  1  4-phase acknowledge to the pins
fsm_state  input  interface_state_t  interface FSM state; new requests accepted only in I_IDLE
out_byte  output  DATA_W  FIFO head data
out_is_key  output  1  FIFO head key flag
out_valid  output  1  FIFO non-empty
out_ready  input  1  router consumes the head this cycle
reset_hash_pulse  output  1  single-cycle hash reset
fifo_count  output  $clog2(FIFO_DEPTH+1)  current occupancy

Behaviour:
- Reset (nrst=0 at a clk edge):
  - input_ack=0, reset_hash_pulse=0, FIFO emptied (out_valid=0, fifo_count=0, out_byte=0, out_is_key=0).
  - State is S_REARM.
  - Synchroniser flops reset to all-ones.
- req_s is the last synchroniser stage. input_byte, is_key and reset_hash are sampled directly (bundled data), never synchronised.
- State S_REARM: waits for req_s==0, then goes to S_IDLE. A request held high through reset is never captured.
- State S_IDLE: a request is accepted when req_s==1, fsm_state==I_IDLE and (reset_hash==1 or fifo_count<FIFO_DEPTH).
  - On accept with reset_hash==1: reset_hash_pulse=1 for exactly one cycle. Nothing is pushed, and is_key is ignored. reset_hash has priority over data.
  - On accept with reset_hash==0: {input_byte, is_key} is pushed to the FIFO tail.
  - On accept, in both cases: input_ack<=1 on the same edge and the state goes to S_ACK.
  - If the conditions are not met, the state holds and ack stays 0. A full FIFO or a non-idle FSM stalls the host.
- State S_ACK: input_ack stays 1 until req_s==0. On that edge input_ack<=0 and the state goes to S_IDLE.
  - fsm_state is ignored once a request is accepted; the handshake always completes.
- Latency: the input_request pin rises before edge k. It is visible as req_s at edge k+SYNC_STAGES-1. Accept, ack and the pulse take effect at edge k+SYNC_STAGES.
  - Ack deassertion follows the same synchroniser delay after the pin falls.
  - Exactly one action per handshake.
- FIFO:
  - Pushed data is visible at out_byte/out_valid on the cycle after the push edge. There is no bypass.
  - Pop occurs when out_valid && out_ready. out_ready is ignored when empty.
  - Simultaneous push and pop: count is unchanged and order is preserved.
  - No push when full. Accept uses the current-cycle count, so a same-cycle pop does not enable a push.
  - Pointers wrap modulo FIFO_DEPTH.
  - Overflow and underflow are impossible by construction.
- fifo_count changes only on push xor pop.

Test Plan:
- Single byte, SYNC_STAGES=2. Out of reset, raise input_request with input_byte=0xA5, is_key=1, out_ready=1. Required: input_ack rises 2 edges after the request is seen, and out_valid=1 with out_byte=0xA5, out_is_key=1 one cycle later, for one cycle. Drop the request: input_ack falls 2 edges later.
- Hash reset priority. Request with reset_hash=1, input_byte=0x3C. Required: reset_hash_pulse high for exactly one cycle, fifo_count stays 0, ack completes normally.
- Backpressure, FIFO_DEPTH=4, out_ready=0. Send 5 bytes 0x01..0x05. Required: 4 acks and fifo_count=4; the 5th request gets no ack. Raise out_ready: 0x01 pops, then the 5th is acked. Drain order is 0x01..0x05.
- FSM gating. fsm_state≠I_IDLE with the request high: no ack, no push. Switch to I_IDLE: accepted within 1 cycle. Change fsm_state during S_ACK: the handshake still completes.
- Reset mid-handshake. Assert nrst=0 while in S_ACK with 2 bytes queued and input_request held high. Required: ack=0 and fifo_count=0 after reset; no capture until the request goes low and high again.
- Concurrent push and pop. With fifo_count=2 and out_ready=1, accept a byte. Required: fifo_count stays 2, FIFO order is preserved, and pointers wrap correctly over 10 consecutive bytes.
